// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents:
//   ILEN             - instruction width in bits
//   DEFAULT_RESET_PC - PC loaded on reset unless overridden
//   NOP              - canonical RISC-V NOP (addi x0, x0, 0)
//   state_t / ST_*   - 2-bit fetch FSM encoding
//   is_aligned()     - word-alignment test on the low address bits
package instr_fetch_unit_pkg;

  localparam int          ILEN             = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0013;

  typedef logic [1:0] state_t;

  localparam state_t ST_BOOT  = 2'd0;
  localparam state_t ST_FETCH = 2'd1;
  localparam state_t ST_EXEC  = 2'd2;
  localparam state_t ST_FAULT = 2'd3;

  // Instructions are 32-bit with no compressed extension.
  // A target is legal only when it is word aligned.
  function automatic logic is_aligned(input logic [1:0] low_bits);
    return (low_bits == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus.
// Signals:
//   imem_req   - fetch request, held until acknowledged
//   imem_addr  - word address being fetched
//   imem_ack   - response valid
//   imem_rdata - instruction word, meaningful only when imem_ack is 1
// Modports:
//   master - fetch unit side
//   slave  - memory side
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/instr_fetch_unit_pc_reg.sv
// Program counter register.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - synchronous active-low reset, loads RESET_PC
//   load    - capture next_pc on this edge
//   next_pc - next PC value, already selected by the caller
//   pc      - current PC
module instr_fetch_unit_pc_reg
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage of the single-cycle RISC-V core.
// Owns the PC and fetches one instruction at a time over a req/ack bus.
// Each instruction is then presented to decode for one execute window.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   PCSrc       - 1 selects PCTarget as next PC, 0 selects PC+4 (EXEC only)
//   PCTarget    - branch/jump target from the ALU path
//   Stall       - downstream not done, hold the current instruction
//   imem        - instruction memory bus (master side)
//   Instr       - registered instruction word
//   PC          - address of Instr
//   PCPlus4     - PC + 4, combinational
//   InstrValid  - Instr is live this cycle
//   Fault       - sticky misaligned-target fault
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 PCSrc,
  input  logic [XLEN-1:0]      PCTarget,
  input  logic                 Stall,
  instr_fetch_unit_if.master   imem,
  output logic [XLEN-1:0]      Instr,
  output logic [XLEN-1:0]      PC,
  output logic [XLEN-1:0]      PCPlus4,
  output logic                 InstrValid,
  output logic                 Fault
);

  state_t          state;
  state_t          state_next;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] next_pc;
  logic            pc_load;
  logic            target_misaligned;

  // Wraps modulo 2^XLEN, so 0xFFFF_FFFC + 4 is 0.
  assign PCPlus4           = PC + XLEN'(4);
  assign target_misaligned = !is_aligned(PCTarget[1:0]);

  // This mux sits at the end of the critical path Instr -> control -> ALU -> PC.
  assign next_pc = PCSrc ? PCTarget : PCPlus4;

  // A misaligned taken target parks the FSM in FAULT and leaves the PC at the
  // offending instruction, so it can be inspected after the fault is raised.
  always_comb begin
    state_next = state;
    pc_load    = 1'b0;
    case (state)
      ST_BOOT: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.imem_ack) begin
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!Stall) begin
          if (PCSrc && target_misaligned) begin
            state_next = ST_FAULT;
          end else begin
            state_next = ST_FETCH;
            pc_load    = 1'b1;
          end
        end
      end
      ST_FAULT: begin
        state_next = ST_FAULT;
      end
      default: begin
        state_next = ST_BOOT;
      end
    endcase
  end

  // BOOT gives one quiet cycle after reset so a response from a request that
  // was in flight when reset hit is not mistaken for the first fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // An ack is only meaningful while a request is outstanding.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr_q <= '0;
    end else if ((state == ST_FETCH) && imem.imem_ack) begin
      instr_q <= imem.imem_rdata;
    end
  end

  instr_fetch_unit_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (pc_load),
    .next_pc (next_pc),
    .pc      (PC)
  );

  assign imem.imem_req  = (state == ST_FETCH);
  assign imem.imem_addr = PC;
  assign Instr          = instr_q;
  assign InstrValid     = (state == ST_EXEC);
  assign Fault          = (state == ST_FAULT);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
// Inputs change and outputs are sampled on the falling clock edge, so every
// observation sees the state produced by the preceding rising edge.
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  localparam logic [31:0] ADDI  = 32'h00A0_0093;
  localparam logic [31:0] BEQ   = 32'h0020_8463;
  localparam logic [31:0] JUNK  = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        Stall;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        InstrValid;
  logic        Fault;

  int checks;
  int failures;

  instr_fetch_unit_if #(.XLEN(32)) imem_bus ();

  instr_fetch_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCSrc      (PCSrc),
    .PCTarget   (PCTarget),
    .Stall      (Stall),
    .imem       (imem_bus),
    .Instr      (Instr),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .InstrValid (InstrValid),
    .Fault      (Fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset, checks the reset state, then releases; ends in FETCH at PC 0.
  task automatic test_reset();
    rst_n = 1'b0; PCSrc = 1'b0; PCTarget = '0; Stall = 1'b0;
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (PC !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h want=%h", PC, 32'h0); end
    checks++; if (Instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h want=%h", Instr, 32'h0); end
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b want=0", InstrValid); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b want=0", imem_bus.imem_req); end
    checks++; if (Fault !== 1'b0) begin failures++; $display("[TB] FAIL reset_fault got=%b want=0", Fault); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Zero-latency acks: fetch 0, 4, 8 with InstrValid every other cycle.
  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(4 * i);
      checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL seq_req[%0d] got=%b want=1", i, imem_bus.imem_req); end
      checks++; if (imem_bus.imem_addr !== exp_pc) begin failures++; $display("[TB] FAIL seq_addr[%0d] got=%h want=%h", i, imem_bus.imem_addr, exp_pc); end
      checks++; if (InstrValid !== 1'b0) begin failures++; $display("[TB] FAIL seq_valid_fetch[%0d] got=%b want=0", i, InstrValid); end
      imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = NOP;
      @(negedge clk);
      imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
      checks++; if (InstrValid !== 1'b1) begin failures++; $display("[TB] FAIL seq_valid_exec[%0d] got=%b want=1", i, InstrValid); end
      checks++; if (Instr !== NOP) begin failures++; $display("[TB] FAIL seq_instr[%0d] got=%h want=%h", i, Instr, NOP); end
      checks++; if (PC !== exp_pc) begin failures++; $display("[TB] FAIL seq_pc[%0d] got=%h want=%h", i, PC, exp_pc); end
      checks++; if (PCPlus4 !== exp_pc + 32'd4) begin failures++; $display("[TB] FAIL seq_pcplus4[%0d] got=%h want=%h", i, PCPlus4, exp_pc + 32'd4); end
      @(negedge clk);
    end
  endtask

  // Ack after three idle FETCH cycles; then a spurious ack while req is low.
  task automatic test_ack_latency();
    imem_bus.imem_rdata = JUNK;
    for (int k = 0; k < 3; k++) begin
      checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL lat_req[%0d] got=%b want=1", k, imem_bus.imem_req); end
      checks++; if (imem_bus.imem_addr !== 32'hC) begin failures++; $display("[TB] FAIL lat_addr[%0d] got=%h want=%h", k, imem_bus.imem_addr, 32'hC); end
      checks++; if (Instr !== NOP) begin failures++; $display("[TB] FAIL lat_instr_hold[%0d] got=%h want=%h", k, Instr, NOP); end
      checks++; if (InstrValid !== 1'b0) begin failures++; $display("[TB] FAIL lat_valid[%0d] got=%b want=0", k, InstrValid); end
      @(negedge clk);
    end
    checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL lat_req_ack got=%b want=1", imem_bus.imem_req); end
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = ADDI;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    checks++; if (Instr !== ADDI) begin failures++; $display("[TB] FAIL lat_instr got=%h want=%h", Instr, ADDI); end
    checks++; if (InstrValid !== 1'b1) begin failures++; $display("[TB] FAIL lat_valid_exec got=%b want=1", InstrValid); end
    checks++; if (PC !== 32'hC) begin failures++; $display("[TB] FAIL lat_pc got=%h want=%h", PC, 32'hC); end
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = JUNK;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    checks++; if (Instr !== ADDI) begin failures++; $display("[TB] FAIL spurious_ack_instr got=%h want=%h", Instr, ADDI); end
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("[TB] FAIL spurious_ack_valid got=%b want=0", InstrValid); end
    checks++; if (imem_bus.imem_addr !== 32'h10) begin failures++; $display("[TB] FAIL spurious_ack_addr got=%h want=%h", imem_bus.imem_addr, 32'h10); end
  endtask

  // Five stalled EXEC cycles at PC 0x10, then a taken branch to 0x100.
  task automatic test_stall_branch();
    Stall = 1'b1;
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = BEQ;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (InstrValid !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid[%0d] got=%b want=1", i, InstrValid); end
      checks++; if (PC !== 32'h10) begin failures++; $display("[TB] FAIL stall_pc[%0d] got=%h want=%h", i, PC, 32'h10); end
      checks++; if (Instr !== BEQ) begin failures++; $display("[TB] FAIL stall_instr[%0d] got=%h want=%h", i, Instr, BEQ); end
      checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL stall_req[%0d] got=%b want=0", i, imem_bus.imem_req); end
      @(negedge clk);
    end
    checks++; if (InstrValid !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_valid got=%b want=1", InstrValid); end
    Stall = 1'b0; PCSrc = 1'b1; PCTarget = 32'h0000_0100;
    @(negedge clk);
    PCSrc = 1'b0;
    checks++; if (imem_bus.imem_addr !== 32'h100) begin failures++; $display("[TB] FAIL branch_addr got=%h want=%h", imem_bus.imem_addr, 32'h100); end
    checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL branch_req got=%b want=1", imem_bus.imem_req); end
  endtask

  // Jump to 0xFFFF_FFFC, fall through to wrap to 0, self-loop at 0, step to 4.
  task automatic test_wrap_self_loop();
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = NOP;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    PCSrc = 1'b1; PCTarget = 32'hFFFF_FFFC;
    @(negedge clk);
    PCSrc = 1'b0;
    checks++; if (imem_bus.imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_top_addr got=%h want=%h", imem_bus.imem_addr, 32'hFFFF_FFFC); end
    imem_bus.imem_ack = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    checks++; if (PCPlus4 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_pcplus4 got=%h want=%h", PCPlus4, 32'h0); end
    @(negedge clk);
    checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL wrap_addr got=%h want=%h", imem_bus.imem_addr, 32'h0); end
    checks++; if (Fault !== 1'b0) begin failures++; $display("[TB] FAIL wrap_fault got=%b want=0", Fault); end
    imem_bus.imem_ack = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    PCSrc = 1'b1; PCTarget = 32'h0;
    @(negedge clk);
    PCSrc = 1'b0;
    checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL selfloop_addr got=%h want=%h", imem_bus.imem_addr, 32'h0); end
    checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL selfloop_req got=%b want=1", imem_bus.imem_req); end
    checks++; if (Fault !== 1'b0) begin failures++; $display("[TB] FAIL selfloop_fault got=%b want=0", Fault); end
    imem_bus.imem_ack = 1'b1;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (imem_bus.imem_addr !== 32'h4) begin failures++; $display("[TB] FAIL step_addr got=%h want=%h", imem_bus.imem_addr, 32'h4); end
  endtask

  // Misaligned target from PC 4: Fault sticks until reset.
  task automatic test_fault();
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = NOP;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    checks++; if (InstrValid !== 1'b1) begin failures++; $display("[TB] FAIL fault_pre_valid got=%b want=1", InstrValid); end
    PCSrc = 1'b1; PCTarget = 32'h0000_0102;
    @(negedge clk);
    PCSrc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (Fault !== 1'b1) begin failures++; $display("[TB] FAIL fault_flag[%0d] got=%b want=1", i, Fault); end
      checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL fault_req[%0d] got=%b want=0", i, imem_bus.imem_req); end
      checks++; if (InstrValid !== 1'b0) begin failures++; $display("[TB] FAIL fault_valid[%0d] got=%b want=0", i, InstrValid); end
      checks++; if (PC !== 32'h4) begin failures++; $display("[TB] FAIL fault_pc[%0d] got=%h want=%h", i, PC, 32'h4); end
      imem_bus.imem_ack = 1'b1;
      @(negedge clk);
    end
    imem_bus.imem_ack = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (Fault !== 1'b0) begin failures++; $display("[TB] FAIL fault_clear got=%b want=0", Fault); end
    checks++; if (PC !== 32'h0) begin failures++; $display("[TB] FAIL fault_reset_pc got=%h want=%h", PC, 32'h0); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reset while FETCH waits on an ack due next cycle; the late ack is dropped.
  task automatic test_reset_midfetch();
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = NOP;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    @(negedge clk);
    checks++; if (imem_bus.imem_addr !== 32'h4) begin failures++; $display("[TB] FAIL midfetch_addr got=%h want=%h", imem_bus.imem_addr, 32'h4); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("[TB] FAIL midfetch_req got=%b want=0", imem_bus.imem_req); end
    checks++; if (Instr !== 32'h0) begin failures++; $display("[TB] FAIL midfetch_instr got=%h want=%h", Instr, 32'h0); end
    checks++; if (PC !== 32'h0) begin failures++; $display("[TB] FAIL midfetch_pc got=%h want=%h", PC, 32'h0); end
    rst_n = 1'b1;
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = JUNK;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("[TB] FAIL boot_req got=%b want=1", imem_bus.imem_req); end
    checks++; if (Instr !== 32'h0) begin failures++; $display("[TB] FAIL late_ack_instr got=%h want=%h", Instr, 32'h0); end
    checks++; if (InstrValid !== 1'b0) begin failures++; $display("[TB] FAIL late_ack_valid got=%b want=0", InstrValid); end
    checks++; if (imem_bus.imem_addr !== 32'h0) begin failures++; $display("[TB] FAIL refetch_addr got=%h want=%h", imem_bus.imem_addr, 32'h0); end
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = NOP;
    @(negedge clk);
    imem_bus.imem_ack = 1'b0;
    checks++; if (Instr !== NOP) begin failures++; $display("[TB] FAIL refetch_instr got=%h want=%h", Instr, NOP); end
    checks++; if (InstrValid !== 1'b1) begin failures++; $display("[TB] FAIL refetch_valid got=%b want=1", InstrValid); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    $display("[TB] instr_fetch_unit directed tests");
    test_reset();
    test_sequential();
    test_ack_latency();
    test_stall_branch();
    test_wrap_self_loop();
    test_fault();
    test_reset_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage of the single-cycle RISC-V core, directly upstream of the control unit. It owns the program counter and fetches each 32-bit instruction from a variable-latency instruction memory over a req/ack handshake. It then presents `Instr`, `PC` and `PCPlus4` to the decode/control path for one execute window. The branch/jump decision (`PCSrc`, `PCTarget`) comes back from the control/ALU path to select the next PC.

## Interface
Parameters:
- `XLEN`, 32: PC and instruction width.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `PCSrc` in 1: 1 = take `PCTarget`, 0 = `PC+4`; sampled only in EXEC.
- `PCTarget` in XLEN: branch/jump target from the ALU path.
- `Stall` in 1: downstream not done; holds EXEC.
- `imem_req` out 1: fetch request.
- `imem_addr` out XLEN: fetch address, equal to `PC`.
- `imem_ack` in 1: memory response valid.
- `imem_rdata` in XLEN: instruction word, valid when `imem_ack`=1.
- `Instr` out XLEN: registered instruction; `Instr[6:0]`, `[14:12]` and `[30]` feed the control unit.
- `PC` out XLEN: address of `Instr`.
- `PCPlus4` out XLEN: `PC+4`, combinational from `PC`.
- `InstrValid` out 1: `Instr` is live; the core gates `RegWrite`/`MemWrite` with it.
- `Fault` out 1: sticky misaligned-target fault.

## Operation
- FSM states: BOOT, FETCH, EXEC, FAULT.
- Reset (`rst_n`=0 at an edge):
  - state becomes BOOT, `PC`=`RESET_PC`.
  - `Instr`=0, `InstrValid`=0, `imem_req`=0, `Fault`=0.
- BOOT: one cycle with `imem_req`=0, then FETCH. This drains any response still in flight from before reset.
- FETCH:
  - `imem_req`=1, `imem_addr`=`PC`; `imem_req` stays high until ack.
  - On `imem_ack`=1: `Instr` <= `imem_rdata`, go to EXEC.
  - `imem_ack` is ignored while `imem_req`=0.
- EXEC:
  - `InstrValid`=1, `imem_req`=0.
  - If `Stall`=1: hold state, `PC` and `Instr`.
  - If `Stall`=0 and `PCSrc`=0: `PC` <= `PC+4`, go to FETCH.
  - If `Stall`=0, `PCSrc`=1 and `PCTarget[1:0]`==0: `PC` <= `PCTarget`, go to FETCH.
  - If `Stall`=0, `PCSrc`=1 and `PCTarget[1:0]`!=0: go to FAULT, `PC` unchanged.
- FAULT: `Fault`=1, `InstrValid`=0, `imem_req`=0. Only reset leaves this state.
- Arithmetic:
  - `PC+4` is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0 with no fault.
  - `PCSrc`=1 with `PCTarget`==`PC` (self-loop) is legal.
- `InstrValid` is 0 in BOOT, FETCH and FAULT. Downstream architectural state changes only on EXEC cycles with `Stall`=0.

## Timing
- Fetch latency = ack latency L (L≥0 cycles after `imem_req` rises; L=0 means ack in the first FETCH cycle).
- Instruction throughput = L+2 cycles at best: FETCH (L+1 cycles) plus EXEC (1 cycle).
- `Instr` is registered and updates on the edge that ends the ack cycle. `InstrValid` rises on the same edge.
- `PC` updates on the edge that ends the EXEC cycle with `Stall`=0. `imem_addr` shows the new PC in the following FETCH cycle.
- `PCSrc`/`PCTarget` are combinational from the control unit and ALU within the EXEC cycle. This is the critical path: `Instr` → control unit → ALU → next-PC mux → PC register.
- `rst_n` low in any state, including FETCH awaiting ack, takes effect at that edge. `imem_req` drops on the next cycle.

## Structure
- Shared package holds:
  - state encoding (BOOT/FETCH/EXEC/FAULT, 2 bits).
  - `ILEN`=32.
  - the default `RESET_PC`.
  - the `NOP` encoding 32'h0000_0013, used by the bench.
- One natural sub-module: `pc_reg`, the PC register with synchronous active-low reset to `RESET_PC`, load-enable and next-PC mux input.
- The FSM and `Instr` register stay in the top.

## Test plan
- Reset, memory acks with L=0 returning 32'h0000_0013 → `imem_addr`=0, 4, 8 on successive fetches; `InstrValid` pulses 1 cycle every 2 cycles; `PCPlus4`=`PC`+4.
- Ack latency L=3 → `imem_req` held 4 cycles at a stable address; `Instr` captured only on the ack cycle; spurious ack with `imem_req`=0 is ignored.
- EXEC with `Stall`=1 for 5 cycles, then `PCSrc`=1, `PCTarget`=32'h0000_0100 → `PC`/`Instr` frozen for 5 cycles, then next `imem_addr`=32'h100.
- `PCSrc`=1, `PCTarget`=32'h0000_0102 → `Fault`=1 and `imem_req`=0 persist; `PC` stays unchanged until `rst_n`=0.
- `PC`=32'hFFFF_FFFC, `PCSrc`=0 → next `imem_addr`=0, `Fault`=0.
- `rst_n`=0 during FETCH with an ack due next cycle → state BOOT, `imem_req`=0 for 1 cycle, late ack ignored, then fetch from `RESET_PC`.
